// File: rtl/ripple_carry_adder_n_bit.sv
// Purpose : WIDTH-bit ripple-carry adder {co,s} = a + b + ci, signed-overflow flag,
//           and a registered copy of the sum and carry-out.
// Latency : s/co/ovf are combinational (0 cycles); s_q/co_q are 1 cycle after clk_i.
// Backpr. : none; there is no handshake, and the inputs are sampled on every clk_i edge.
//
// Ports:
//   clk_i  - clock, used only by s_q/co_q
//   rst_i  - synchronous active-high reset for s_q/co_q
//   ci     - carry into bit 0
//   a, b   - operands, unsigned or two's complement
//   s      - sum modulo 2^WIDTH (combinational)
//   co     - carry out of bit WIDTH-1 (combinational)
//   ovf    - two's-complement overflow (combinational)
//   s_q    - s registered on the rising edge of clk_i
//   co_q   - co registered on the rising edge of clk_i

// One full-adder cell of the carry chain.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;  // propagate

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder_n_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic [WIDTH-1:0] s_q,
  output logic             co_q
);
  // c[i] is the carry into bit i. c[WIDTH] is the carry out of the top bit.
  logic [WIDTH:0] c;

  assign c[0] = ci;

  // The adder is built from explicit cells so the carry ripples from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rca_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[WIDTH];
  // Overflow occurs when the carry into the sign bit differs from the carry out of it.
  // When WIDTH is 1, c[WIDTH-1] is c[0], which is ci.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s;
      co_q <= co;
    end
  end
endmodule

// File: tb/tb_ripple_carry_adder_n_bit.sv
module tb_ripple_carry_adder_n_bit;
  logic clk_i = 1'b0;
  logic rst_i;

  // WIDTH = 32
  logic        ci32;
  logic [31:0] a32, b32, s32, s_q32;
  logic        co32, ovf32, co_q32;
  // WIDTH = 8
  logic        ci8;
  logic [7:0]  a8, b8, s8, s_q8;
  logic        co8, ovf8, co_q8;
  // WIDTH = 1
  logic        ci1;
  logic [0:0]  a1, b1, s1, s_q1;
  logic        co1, ovf1, co_q1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ripple_carry_adder_n_bit u_dut32 (
    .clk_i(clk_i), .rst_i(rst_i), .ci(ci32), .a(a32), .b(b32),
    .s(s32), .co(co32), .ovf(ovf32), .s_q(s_q32), .co_q(co_q32)
  );

  ripple_carry_adder_n_bit #(.WIDTH(8)) u_dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .ci(ci8), .a(a8), .b(b8),
    .s(s8), .co(co8), .ovf(ovf8), .s_q(s_q8), .co_q(co_q8)
  );

  ripple_carry_adder_n_bit #(.WIDTH(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .ci(ci1), .a(a1), .b(b1),
    .s(s1), .co(co1), .ovf(ovf1), .s_q(s_q1), .co_q(co_q1)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Directed vector for WIDTH=32 with hand-computed results.
  task automatic vec32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [31:0] es, input logic eco, input logic eovf);
    a32 = a; b32 = b; ci32 = ci;
    #1;
    check_val({tag, ".s"},   64'(s32),   64'(es));
    check_val({tag, ".co"},  64'(co32),  64'(eco));
    check_val({tag, ".ovf"}, 64'(ovf32), 64'(eovf));
  endtask

  task automatic vec8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [7:0] es, input logic eco, input logic eovf);
    a8 = a; b8 = b; ci8 = ci;
    #1;
    check_val({tag, ".s"},   64'(s8),   64'(es));
    check_val({tag, ".co"},  64'(co8),  64'(eco));
    check_val({tag, ".ovf"}, 64'(ovf8), 64'(eovf));
  endtask

  task automatic vec1(input string tag, input logic a, input logic b,
                      input logic ci, input logic es, input logic eco, input logic eovf);
    a1 = a; b1 = b; ci1 = ci;
    #1;
    check_val({tag, ".s"},   64'(s1),   64'(es));
    check_val({tag, ".co"},  64'(co1),  64'(eco));
    check_val({tag, ".ovf"}, 64'(ovf1), 64'(eovf));
  endtask

  initial begin
    logic [63:0] ref_sum;
    logic        ref_ovf;

    rst_i = 1'b1;
    a32 = '0; b32 = '0; ci32 = 1'b0;
    a8  = '0; b8  = '0; ci8  = 1'b0;
    a1  = '0; b1  = '0; ci1  = 1'b0;

    // Reset state
    @(posedge clk_i); #1;
    check_val("rst.s_q32",  64'(s_q32),  64'd0);
    check_val("rst.co_q32", 64'(co_q32), 64'd0);
    check_val("rst.s_q8",   64'(s_q8),   64'd0);
    check_val("rst.s_q1",   64'(s_q1),   64'd0);

    // Combinational directed vectors, WIDTH=32
    vec32("add5_7",    32'd5,          32'd7,          1'b0, 32'd12,         1'b0, 1'b0);
    vec32("uwrap",     32'hFFFF_FFFF, 32'd1,          1'b0, 32'd0,          1'b1, 1'b0);
    vec32("pos_ovf",   32'h7FFF_FFFF, 32'd1,          1'b0, 32'h8000_0000, 1'b0, 1'b1);
    vec32("neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0,          1'b1, 1'b1);
    vec32("ripple",    32'hFFFF_FFFF, 32'd0,          1'b1, 32'd0,          1'b1, 1'b0);
    vec32("ci_only",   32'd0,          32'd0,          1'b1, 32'd1,          1'b0, 1'b0);
    vec32("neg1_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    vec32("alt_bits",  32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vec32("ci_ovf",    32'h7FFF_FFFF, 32'd0,          1'b1, 32'h8000_0000, 1'b0, 1'b1);

    // WIDTH=8
    vec8("w8.pos_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    vec8("w8.wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    vec8("w8.mix",     8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0);
    vec8("w8.neg_ovf", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);

    // WIDTH=1: c[0]=ci takes the place of the sign-bit carry-in
    vec1("w1.11_0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    vec1("w1.00_1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    vec1("w1.10_1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    vec1("w1.10_0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Registered path. Inputs change on the falling edge.
    @(negedge clk_i);
    rst_i = 1'b0;
    a32 = 32'd3; b32 = 32'd4; ci32 = 1'b0;
    @(posedge clk_i); #1;
    check_val("reg.s_q",  64'(s_q32),  64'd7);
    check_val("reg.co_q", 64'(co_q32), 64'd0);

    // A mid-operation reset clears the registers and leaves the combinational sum unchanged.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_val("midrst.s_q",  64'(s_q32),  64'd0);
    check_val("midrst.co_q", 64'(co_q32), 64'd0);
    check_val("midrst.s",    64'(s32),    64'd7);

    @(negedge clk_i);
    rst_i = 1'b0;
    a32 = 32'hFFFF_FFFF; b32 = 32'd1;
    @(posedge clk_i); #1;
    check_val("reg.wrap.s_q",  64'(s_q32),  64'd0);
    check_val("reg.wrap.co_q", 64'(co_q32), 64'd1);

    @(negedge clk_i);
    a32 = 32'd100; b32 = 32'd23; ci32 = 1'b1;
    @(posedge clk_i); #1;
    check_val("reg.124.s_q",  64'(s_q32),  64'd124);
    check_val("reg.124.co_q", 64'(co_q32), 64'd0);

    // Random sweep against a reference sum. The overflow reference uses the sign rule:
    // same operand signs and a different result sign.
    for (int i = 0; i < 10000; i++) begin
      a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom_range(0, 1));
      a8  = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
      ci8 = 1'($urandom_range(0, 1));
      a1  = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
      ci1 = 1'($urandom_range(0, 1));
      #1;
      ref_sum = 64'(a32) + 64'(b32) + 64'(ci32);
      ref_ovf = (a32[31] == b32[31]) && (ref_sum[31] != a32[31]);
      check_val("rnd32.cos", 64'({co32, s32}), ref_sum);
      check_val("rnd32.ovf", 64'(ovf32), 64'(ref_ovf));
      ref_sum = 64'(a8) + 64'(b8) + 64'(ci8);
      ref_ovf = (a8[7] == b8[7]) && (ref_sum[7] != a8[7]);
      check_val("rnd8.cos", 64'({co8, s8}), ref_sum);
      check_val("rnd8.ovf", 64'(ovf8), 64'(ref_ovf));
      ref_sum = 64'(a1) + 64'(b1) + 64'(ci1);
      ref_ovf = (a1[0] == b1[0]) && (ref_sum[0] != a1[0]);
      check_val("rnd1.cos", 64'({co1, s1}), ref_sum);
      check_val("rnd1.ovf", 64'(ovf1), 64'(ref_ovf));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
